trace_capture: RTL and testbench

Hardware consumer for the core's instruction trace port. Accepts `trace_valid`/`trace_data` words, buffers them in a small FIFO, and streams each word out as a 5-byte frame over a valid/ready byte interface toward a UART or debug link. Dropped words are counted and flagged in the stream. Capture stops on `trap`, and `done` is raised once the buffer has drained.

---
 rtl/trace_capture_pkg.sv | 38 +++
 rtl/trace_capture_fifo.sv | 93 +++++++++
 rtl/trace_capture.sv | 201 ++++++++++++++++++++
 tb/tb_trace_capture.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_capture_pkg.sv
// -----------------------------------------------------------------------------
// trace_capture_pkg
// Shared definitions for the trace capture block: trace word width, frame
// geometry, position of the overflow marker inside a FIFO entry, the
// serializer state type and the byte-lane selector used to build frames.
// -----------------------------------------------------------------------------
package trace_capture_pkg;

   localparam int TRACE_W     = 36;
   localparam int FRAME_BYTES = 5;
   localparam int OVF_BIT     = 36;
   // FIFO entry is {ovf, trace_data}
   localparam int ENTRY_W     = TRACE_W + 1;
   localparam int IDX_W       = 3;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_e;

   // Returns byte 'idx' of the frame for one FIFO entry.
   // byte0 carries the overflow marker and the top nibble of the trace word,
   // bytes 1..4 carry the remaining 32 bits most-significant first.
   function automatic logic [7:0] frame_byte(input logic [ENTRY_W-1:0] entry,
                                             input logic [IDX_W-1:0]   idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = {entry[OVF_BIT], 3'b000, entry[35:32]};
         3'd1:    b = entry[31:24];
         3'd2:    b = entry[23:16];
         3'd3:    b = entry[15:8];
         3'd4:    b = entry[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/trace_capture_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Generic synchronous first-word-fall-through FIFO.
//   clk_i    : clock, rising edge
//   reset_i  : synchronous active-high reset (empties the FIFO)
//   push_i   : write din_i (ignored when full)
//   pop_i    : discard the head entry (ignored when empty)
//   din_i    : write data
//   dout_o   : head entry, valid whenever empty_o is low
//   level_o  : occupancy 0..DEPTH
//   full_o   : level_o == DEPTH
//   empty_o  : level_o == 0
// Pointers wrap modulo DEPTH; the separate count tells full from empty.
// -----------------------------------------------------------------------------
module trace_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 16
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       din_i,
   output logic [WIDTH-1:0]       dout_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int             PTR_W     = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_LVL = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0] ZERO_LVL  = (PTR_W + 1)'(0);
   localparam logic [PTR_W:0] ONE_LVL   = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   // Qualify requests against the current occupancy and derive next state
   always_comb begin
      push_ok  = push_i && (count_q != DEPTH_LVL);
      pop_ok   = pop_i && (count_q != ZERO_LVL);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + ONE_LVL;
         2'b01:   count_d = count_q - ONE_LVL;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= PTR_ZERO;
         rd_ptr_q <= PTR_ZERO;
         count_q  <= ZERO_LVL;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; no reset needed because the count gates every read
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign level_o = count_q;
   assign full_o  = (count_q == DEPTH_LVL);
   assign empty_o = (count_q == ZERO_LVL);

endmodule

// File: rtl/trace_capture.sv
// -----------------------------------------------------------------------------
// trace_capture
// Consumes the core's instruction trace port, buffers words in a FIFO and
// streams each as a 5-byte frame on a valid/ready byte interface.
//   clk_i            : clock, rising edge
//   reset_i          : synchronous active-high reset
//   trace_valid_i    : trace word present (no backpressure to the core)
//   trace_data_i     : 36-bit trace word
//   trap_i           : core trapped (level); stops capture from next cycle
//   out_valid_o      : byte available
//   out_ready_i      : sink accepts the byte
//   out_data_o       : stream byte
//   dropped_count_o  : words lost to a full FIFO, saturating
//   fifo_level_o     : current FIFO occupancy
//   done_o           : capture stopped and everything sent (sticky)
// -----------------------------------------------------------------------------
module trace_capture
   import trace_capture_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   trace_valid_i,
   input  logic [TRACE_W-1:0]     trace_data_i,
   input  logic                   trap_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [7:0]             out_data_o,
   output logic [15:0]            dropped_count_o,
   output logic [$clog2(DEPTH):0] fifo_level_o,
   output logic                   done_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

   // FIFO side
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_pop;
   logic [ENTRY_W-1:0] fifo_din;
   logic [ENTRY_W-1:0] fifo_dout;
   logic               push_en;
   logic               drop_en;

   // Serializer
   ser_state_e         state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [ENTRY_W-1:0] frame_q, frame_d;
   logic               out_valid_q, out_valid_d;
   logic [7:0]         out_data_q, out_data_d;

   // Capture control
   logic [15:0]        dropped_q, dropped_d;
   logic               pending_ovf_q, pending_ovf_d;
   logic               stopped_q, stopped_d;
   logic               done_q, done_d;

   trace_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (push_en),
      .pop_i   (fifo_pop),
      .din_i   (fifo_din),
      .dout_o  (fifo_dout),
      .level_o (fifo_level_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Accept/drop decision; full is the pre-pop occupancy so a pop in the
   // same cycle never frees a slot for the incoming word
   always_comb begin
      push_en  = trace_valid_i && !fifo_full && !stopped_q;
      drop_en  = trace_valid_i && fifo_full && !stopped_q;
      fifo_din = {pending_ovf_q, trace_data_i};
   end

   // Drop counter, overflow marker, stop latch and sticky done: next state
   always_comb begin
      dropped_d     = dropped_q;
      pending_ovf_d = pending_ovf_q;
      stopped_d     = stopped_q;
      done_d        = done_q;
      if (drop_en && (dropped_q != 16'hFFFF)) begin
         dropped_d = dropped_q + 16'd1;
      end else begin
         dropped_d = dropped_q;
      end
      // The marker rides on the next accepted word, then clears
      if (push_en) begin
         pending_ovf_d = 1'b0;
      end else if (drop_en) begin
         pending_ovf_d = 1'b1;
      end else begin
         pending_ovf_d = pending_ovf_q;
      end
      if (trap_i) begin
         stopped_d = 1'b1;
      end else begin
         stopped_d = stopped_q;
      end
      done_d = done_q || (stopped_q && fifo_empty && (state_q == IDLE));
   end

   // Capture control registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         dropped_q     <= 16'h0000;
         pending_ovf_q <= 1'b0;
         stopped_q     <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         dropped_q     <= dropped_d;
         pending_ovf_q <= pending_ovf_d;
         stopped_q     <= stopped_d;
         done_q        <= done_d;
      end
   end

   // Serializer FSM: loads the FIFO head into the frame register and walks
   // the five byte lanes; out_data/out_valid are registered and only change
   // on a handshake or when a frame is loaded from IDLE
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      frame_d     = frame_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      fifo_pop    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop    = 1'b1;
               state_d     = SEND;
               idx_d       = 3'd0;
               frame_d     = fifo_dout;
               out_valid_d = 1'b1;
               out_data_d  = frame_byte(fifo_dout, 3'd0);
            end else begin
               out_valid_d = 1'b0;
            end
         end
         SEND: begin
            if (out_valid_q && out_ready_i) begin
               if (idx_q == LAST_IDX) begin
                  // Chain straight into the next frame when data is waiting
                  if (!fifo_empty) begin
                     fifo_pop    = 1'b1;
                     idx_d       = 3'd0;
                     frame_d     = fifo_dout;
                     out_valid_d = 1'b1;
                     out_data_d  = frame_byte(fifo_dout, 3'd0);
                  end else begin
                     state_d     = IDLE;
                     out_valid_d = 1'b0;
                     out_data_d  = 8'h00;
                  end
               end else begin
                  idx_d      = idx_q + 3'd1;
                  out_data_d = frame_byte(frame_q, idx_q + 3'd1);
               end
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d     = IDLE;
            idx_d       = 3'd0;
            out_valid_d = 1'b0;
            out_data_d  = 8'h00;
         end
      endcase
   end

   // Serializer registers; reset abandons any frame in flight
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         idx_q       <= 3'd0;
         frame_q     <= {ENTRY_W{1'b0}};
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         frame_q     <= frame_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid_o     = out_valid_q;
   assign out_data_o      = out_data_q;
   assign dropped_count_o = dropped_q;
   assign done_o          = done_q;

endmodule

// File: tb/tb_trace_capture.sv
// -----------------------------------------------------------------------------
// tb_trace_capture
// Self-checking bench for trace_capture (DEPTH=4). A behavioural model keeps
// FIFO occupancy as a number, the frame in service as a count of bytes still
// owed, and the expected byte stream as a queue filled when a word is accepted.
// -----------------------------------------------------------------------------
module tb_trace_capture;

   localparam int DEPTH = 4;
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              trace_valid = 1'b0;
   logic [35:0]       trace_data = 36'h0;
   logic              trap = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [7:0]        out_data;
   logic [15:0]       dropped_count;
   logic [LVL_W-1:0]  fifo_level;
   logic              done;

   int total = 0;
   int bad = 0;

   // reference model state
   int         m_occ;
   bit         m_busy;
   int         m_rem;
   int         m_dropped;
   bit         m_pend;
   bit         m_stopped;
   bit         m_done;
   logic [7:0] exp_bytes[$];
   logic [7:0] got_bytes[$];

   trace_capture #(.DEPTH(DEPTH)) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .trace_valid_i   (trace_valid),
      .trace_data_i    (trace_data),
      .trap_i          (trap),
      .out_valid_o     (out_valid),
      .out_ready_i     (out_ready),
      .out_data_o      (out_data),
      .dropped_count_o (dropped_count),
      .fifo_level_o    (fifo_level),
      .done_o          (done)
   );

   always #5 clk = ~clk;

   function automatic logic [35:0] rand_word();
      return {4'($urandom_range(15, 0)), 32'($urandom)};
   endfunction

   function automatic int byte_diffs();
      int n = 0;
      if (got_bytes.size() != exp_bytes.size()) n = n + 1;
      for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
         if (got_bytes[i] !== exp_bytes[i]) n = n + 1;
      return n;
   endfunction

   // Record a handshake, advance the model by one clock, then step the DUT.
   task automatic tick();
      logic [36:0] w;
      bit          full;
      bit          pop;
      bit          nd;
      if (reset) begin
         m_occ = 0; m_busy = 0; m_rem = 0; m_dropped = 0;
         m_pend = 0; m_stopped = 0; m_done = 0;
         exp_bytes.delete();
         got_bytes.delete();
      end else begin
         if (out_valid === 1'b1 && out_ready) got_bytes.push_back(out_data);
         full = (m_occ == DEPTH);
         nd   = m_done || (m_stopped && m_occ == 0 && !m_busy);
         pop  = 0;
         if (!m_busy) begin
            if (m_occ > 0) begin pop = 1; m_busy = 1; m_rem = 5; end
         end else if (out_ready) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               if (m_occ > 0) begin pop = 1; m_rem = 5; end
               else m_busy = 0;
            end
         end
         if (trace_valid && !m_stopped) begin
            if (!full) begin
               w = {m_pend, trace_data};
               exp_bytes.push_back({w[36], 3'b000, w[35:32]});
               exp_bytes.push_back(8'(w >> 24));
               exp_bytes.push_back(8'(w >> 16));
               exp_bytes.push_back(8'(w >> 8));
               exp_bytes.push_back(8'(w));
               m_pend = 0;
               m_occ  = m_occ + 1;
            end else begin
               if (m_dropped < 65535) m_dropped = m_dropped + 1;
               m_pend = 1;
            end
         end
         if (pop) m_occ = m_occ - 1;
         m_done = nd;
         if (trap) m_stopped = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; trace_valid = 1'b0; trap = 1'b0; out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic drain(input int budget, output bit ok);
      ok = 0;
      trace_valid = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (got_bytes.size() >= exp_bytes.size() && out_valid === 1'b0) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (got_bytes.size() >= exp_bytes.size() && out_valid === 1'b0) ok = 1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h want 00", out_data); end
      total++; if (dropped_count !== 16'h0) begin bad++; $display("FAIL reset_dropped: got %0d want 0", dropped_count); end
      total++; if (fifo_level !== LVL_W'(0)) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
   endtask

   task automatic test_single_word();
      logic [7:0] ref_b [5];
      int nd;
      ref_b = '{8'h09, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      do_reset();
      out_ready = 1'b1;
      trace_valid = 1'b1; trace_data = 36'h9_DEAD_BEEF;
      tick();
      trace_valid = 1'b0;
      total++; if (fifo_level !== LVL_W'(1)) begin bad++; $display("FAIL single_level_n1: got %0d want 1", fifo_level); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_valid_n1: got %b want 0", out_valid); end
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== 8'h09) begin bad++; $display("FAIL single_first_byte: got v=%b d=%h want v=1 d=09", out_valid, out_data); end
      for (int i = 0; i < 5; i++) tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_valid_after: got %b want 0", out_valid); end
      nd = (got_bytes.size() == 5) ? 0 : 1;
      for (int i = 0; i < 5 && i < got_bytes.size(); i++) if (got_bytes[i] !== ref_b[i]) nd++;
      total++; if (nd != 0) begin bad++; $display("FAIL single_bytes: got %0d bytes, %0d wrong, want 09 DE AD BE EF", got_bytes.size(), nd); end
   endtask

   task automatic test_backpressure();
      logic [7:0] ref_b [5];
      bit pat [4];
      int held_bad = 0;
      int nd;
      ref_b = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89};
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      do_reset();
      out_ready = 1'b1;
      trace_valid = 1'b1; trace_data = 36'h1_2345_6789;
      tick();
      trace_valid = 1'b0;
      for (int c = 0; c < 60 && got_bytes.size() < 5; c++) begin
         out_ready = pat[c % 4];
         if (out_valid === 1'b1 && got_bytes.size() < exp_bytes.size())
            if (out_data !== exp_bytes[got_bytes.size()]) held_bad++;
         tick();
      end
      out_ready = 1'b1;
      tick();
      total++; if (held_bad != 0) begin bad++; $display("FAIL bp_hold: %0d cycles showed the wrong byte, want 0", held_bad); end
      nd = (got_bytes.size() == 5) ? 0 : 1;
      for (int i = 0; i < 5 && i < got_bytes.size(); i++) if (got_bytes[i] !== ref_b[i]) nd++;
      total++; if (nd != 0) begin bad++; $display("FAIL bp_bytes: got %0d bytes, %0d wrong, want 01 23 45 67 89", got_bytes.size(), nd); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_after: got %b want 0", out_valid); end
   endtask

   task automatic test_overflow();
      int over = 0;
      int bit7_bad = 0;
      int nf;
      bit ok;
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         trace_valid = 1'b1; trace_data = rand_word();
         tick();
         if (fifo_level > LVL_W'(DEPTH)) over++;
      end
      trace_valid = 1'b0;
      tick();
      total++; if (over != 0) begin bad++; $display("FAIL ovf_level_bound: exceeded %0d on %0d cycles", DEPTH, over); end
      // one word sits in the frame register, so four fill the FIFO
      total++; if (fifo_level !== LVL_W'(DEPTH)) begin bad++; $display("FAIL ovf_level: got %0d want %0d", fifo_level, DEPTH); end
      total++; if (dropped_count !== 16'(m_dropped)) begin bad++; $display("FAIL ovf_dropped: got %0d want %0d", dropped_count, m_dropped); end
      out_ready = 1'b1;
      drain(200, ok);
      trace_valid = 1'b1; trace_data = rand_word();
      tick();
      drain(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL ovf_drain: timed out, got %0d of %0d bytes", got_bytes.size(), exp_bytes.size()); end
      nf = got_bytes.size() / 5;
      for (int f = 0; f + 1 < nf; f++) if (got_bytes[5*f][7] !== 1'b0) bit7_bad++;
      total++; if (bit7_bad != 0 || nf < 2) begin bad++; $display("FAIL ovf_early_bit7: %0d early frames marked, %0d frames", bit7_bad, nf); end
      total++; if (nf < 1 || got_bytes[5*(nf-1)][7] !== 1'b1) begin bad++; $display("FAIL ovf_marker: last frame byte0 bit7 not 1 (frames=%0d)", nf); end
      total++; if (byte_diffs() != 0) begin bad++; $display("FAIL ovf_bytes: %0d differences, got %0d want %0d bytes", byte_diffs(), got_bytes.size(), exp_bytes.size()); end
   endtask

   task automatic test_trap_drain();
      bit ok;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         trace_valid = 1'b1; trace_data = rand_word();
         trap = (i >= 2);
         tick();
      end
      trace_valid = 1'b0;
      drain(100, ok);
      total++; if (!ok || got_bytes.size() != 15) begin bad++; $display("FAIL trap_frames: got %0d bytes want 15", got_bytes.size()); end
      total++; if (dropped_count !== 16'h0) begin bad++; $display("FAIL trap_dropped: got %0d want 0", dropped_count); end
      total++; if (byte_diffs() != 0) begin bad++; $display("FAIL trap_bytes: %0d differences", byte_diffs()); end
      for (int c = 0; c < 4 && done !== 1'b1; c++) tick();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL trap_done: got %b want 1", done); end
      tick();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL trap_done_sticky: got %b want 1", done); end
      trap = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      int c;
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         trace_valid = 1'b1; trace_data = rand_word();
         tick();
      end
      trace_valid = 1'b0;
      out_ready = 1'b1;
      c = 0;
      while (got_bytes.size() < 2 && c < 20) begin tick(); c++; end
      total++; if (got_bytes.size() != 2) begin bad++; $display("FAIL mid_setup: got %0d bytes want 2", got_bytes.size()); end
      reset = 1'b1; out_ready = 1'b0;
      tick();
      reset = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", out_valid); end
      total++; if (fifo_level !== LVL_W'(0)) begin bad++; $display("FAIL mid_level: got %0d want 0", fifo_level); end
      total++; if (dropped_count !== 16'h0) begin bad++; $display("FAIL mid_dropped: got %0d want 0", dropped_count); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_no_tail: got %b want 0", out_valid); end
      out_ready = 1'b1;
      trace_valid = 1'b1; trace_data = rand_word();
      tick();
      drain(50, ok);
      total++; if (!ok || got_bytes.size() != 5 || byte_diffs() != 0) begin bad++; $display("FAIL mid_new_frame: got %0d bytes, %0d differences, want 5 clean", got_bytes.size(), byte_diffs()); end
      total++; if (got_bytes.size() < 1 || got_bytes[0][7] !== 1'b0) begin bad++; $display("FAIL mid_marker: byte0 bit7 not 0 after reset"); end
   endtask

   task automatic test_back_to_back();
      int bubbles = 0;
      bit ok;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < 5; k++) begin
            trace_valid = (k == 0); trace_data = rand_word();
            if (got_bytes.size() > 0 && got_bytes.size() < 200 && out_valid !== 1'b1) bubbles++;
            tick();
         end
      end
      trace_valid = 1'b0;
      for (int c = 0; c < 40 && got_bytes.size() < 200; c++) begin
         if (got_bytes.size() > 0 && out_valid !== 1'b1) bubbles++;
         tick();
      end
      drain(20, ok);
      total++; if (got_bytes.size() != 200) begin bad++; $display("FAIL b2b_count: got %0d bytes want 200", got_bytes.size()); end
      total++; if (bubbles != 0) begin bad++; $display("FAIL b2b_bubbles: got %0d want 0", bubbles); end
      total++; if (dropped_count !== 16'h0) begin bad++; $display("FAIL b2b_dropped: got %0d want 0", dropped_count); end
      total++; if (byte_diffs() != 0) begin bad++; $display("FAIL b2b_bytes: %0d differences", byte_diffs()); end
   endtask

   task automatic test_random();
      int e_lvl = 0, e_drp = 0, e_vld = 0, e_dat = 0, e_don = 0;
      bit ok;
      do_reset();
      for (int c = 0; c < 700; c++) begin
         trace_valid = ($urandom_range(9, 0) < 3);
         trace_data  = rand_word();
         out_ready   = ($urandom_range(9, 0) < 7);
         if (c == 450) trap = 1'b1;
         if (fifo_level !== LVL_W'(m_occ)) e_lvl++;
         if (dropped_count !== 16'(m_dropped)) e_drp++;
         if (out_valid !== m_busy) e_vld++;
         if (done !== m_done) e_don++;
         if (out_valid === 1'b1 && got_bytes.size() < exp_bytes.size())
            if (out_data !== exp_bytes[got_bytes.size()]) e_dat++;
         tick();
      end
      trace_valid = 1'b0;
      out_ready = 1'b1;
      drain(200, ok);
      for (int c = 0; c < 4 && done !== 1'b1; c++) tick();
      total++; if (e_lvl != 0) begin bad++; $display("FAIL rnd_level: %0d cycles wrong, want 0", e_lvl); end
      total++; if (e_drp != 0) begin bad++; $display("FAIL rnd_dropped: %0d cycles wrong, want 0 (final %0d vs %0d)", e_drp, dropped_count, m_dropped); end
      total++; if (e_vld != 0) begin bad++; $display("FAIL rnd_valid: %0d cycles wrong, want 0", e_vld); end
      total++; if (e_dat != 0) begin bad++; $display("FAIL rnd_data: %0d cycles wrong, want 0", e_dat); end
      total++; if (e_don != 0) begin bad++; $display("FAIL rnd_done_track: %0d cycles wrong, want 0", e_don); end
      total++; if (!ok || byte_diffs() != 0) begin bad++; $display("FAIL rnd_stream: %0d differences, got %0d want %0d bytes", byte_diffs(), got_bytes.size(), exp_bytes.size()); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL rnd_done: got %b want 1", done); end
      trap = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_backpressure();
      test_overflow();
      test_trap_drain();
      test_reset_mid_frame();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
